load_store_seq: RTL and testbench
=================================

LOAD_STORE_SEQ -- requirements
Module: load_store_seq

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of cycles mem_req may wait for mem_ack; 0 disables the timeout.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  request offered; req_ready  out  1  sequencer can accept.
REQ-005 req_opcode  in  6  MIPS opcode; req_addr  in  32  byte address; req_wdata  in  32  store data (right-justified); req_rd  in  5  load destination register.
REQ-006 mem_req  out  1  memory access active; mem_we  out  1  1=write; mem_addr  out  32  word-aligned address; mem_wdata  out  32  write word.
REQ-007 mem_ack  in  1  access complete; mem_rdata  in  32  read word, valid with mem_ack.
REQ-008 wb_valid  out  1  load result pulse; wb_rd  out  5; wb_data  out  32.
REQ-009 done  out  1  one-cycle pulse per finished request; fault  out  1  one-cycle pulse, coincident with done.

Function
REQ-010 Supported opcodes SHALL be lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011; any other opcode SHALL produce fault with no memory access.
REQ-011 The FSM SHALL have states IDLE, RD, WR and RESP; req_ready SHALL be 1 only in IDLE.
REQ-012 On req_valid&&req_ready the opcode, address, wdata and rd SHALL be latched and the FSM SHALL leave IDLE.
REQ-013 Transitions: IDLE->RD for loads, sb and sh; IDLE->WR for sw; IDLE->RESP for fault cases; RD->RESP (loads) or RD->WR (sb/sh) on mem_ack; WR->RESP on mem_ack; RESP->IDLE always.
REQ-014 mem_req SHALL be 1 throughout RD and WR and 0 elsewhere; mem_addr SHALL be {addr[31:2],2'b00}; mem_we SHALL be 1 only in WR.
REQ-015 Load extraction: byte at lane addr[1:0], half at lane addr[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word.
REQ-016 sb/sh SHALL merge the store data into the word read in RD at the addressed lane, leaving the other lanes unchanged; sw writes req_wdata directly.
REQ-017 Load latency: accept at cycle T, mem_req at T+1, ack at T+k, then wb_valid and done at T+k+1 for one cycle.
REQ-018 mem_ack while mem_req=0 SHALL be ignored; a new request SHALL NOT be accepted in the RESP cycle.
REQ-019 A cycle counter SHALL clear on entry to RD or WR; when TIMEOUT>0 and the count reaches TIMEOUT without ack, mem_req SHALL drop, the FSM SHALL go to RESP with fault, and no writeback or write SHALL occur.
REQ-020 wb_valid SHALL never assert for stores or faulted requests.

Reset
REQ-021 While rst_n=0 the FSM SHALL be IDLE and all outputs SHALL be 0 except req_ready, which SHALL be 1, effective immediately and independent of clk.
REQ-022 Reset mid-operation SHALL abandon the request with no done, fault or wb pulse.

Configuration
REQ-023 With MISALIGN_TRAP_EN defined, lh/lhu/sh with addr[0]=1 and lw/sw with addr[1:0]!=0 SHALL fault without memory access.
REQ-024 Without MISALIGN_TRAP_EN, the unused low address bits SHALL be ignored: halves use addr[1] only, and words use lane 0.

Structure
REQ-025 Package lsu_pkg SHALL hold opcode constants, the state enum, and the lane-merge function.
REQ-026 Load extraction SHALL be a sub-module named load_extract (inputs word, addr[1:0], opcode; output 32-bit result).

Verification
REQ-027 lbu addr 0x1003, rd=7, ack after 2 cycles with rdata 0x80FF1234 -> mem_addr 0x1000, wb_valid with wb_rd=7 and wb_data 0x00000080 for 1 cycle.
REQ-028 lh addr 0x2002, rdata 0x80010000 -> wb_data 0xFFFF8001.
REQ-029 sb addr 0x0001, wdata 0x000000AB, read returns 0x11223344 -> WR at 0x0 with mem_wdata 0x1122AB44, done, no wb_valid.
REQ-030 lw addr 0x0006 -> with the macro: fault+done one cycle after accept and no mem_req; without the macro: read at 0x0004.
REQ-031 TIMEOUT=4, lw with no ack -> mem_req high exactly 4 cycles, then fault+done, req_ready back to 1.
REQ-032 rst_n low during WR -> mem_req=0 immediately, no done; after release req_ready=1 and a following sw completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: MIPS load/store opcodes,
// the sequencer state enum, opcode classifiers and the store lane merge.
package lsu_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Insert the right-justified store data into the lane selected by the
  // low address bits; untouched lanes keep the word read from memory.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  lane,
                                             input logic [5:0]  op);
    logic [31:0] r;
    r = word;
    if (op == OP_SB)
      r[{lane, 3'b000} +: 8] = data[7:0];
    else if (op == OP_SH)
      r[{lane[1], 4'b0000} +: 16] = data[15:0];
    else
      r = data;
    return r;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/half/word from a read word and sign- or
// zero-extends it according to the load opcode.
module load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [5:0]  opcode,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select and extension; halves use addr[1] only, words ignore addr.
  always_comb begin
    byte_v = word[{addr, 3'b000} +: 8];
    half_v = word[{addr[1], 4'b0000} +: 16];
    unique case (opcode)
      OP_LB:   result = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  result = {24'h0, byte_v};
      OP_LH:   result = {{16{half_v[15]}}, half_v};
      OP_LHU:  result = {16'h0, half_v};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_seq.sv
// MIPS load/store sequencer: accepts one request at a time, performs the
// memory read and/or write (read-modify-write for sb/sh), then pulses done
// (with fault or a load writeback) for one cycle.
// Optional build macro: MISALIGN_TRAP_EN -- misaligned lh/lhu/sh/lw/sw fault
// without a memory access; when undefined the unused low address bits are
// ignored.
module load_store_seq
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        fault
);

  localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [5:0]  op_q;
  logic [31:0] addr_q;
  logic [4:0]  rd_q;
  logic [31:0] wdata_q;
  logic [31:0] wb_data_q;
  logic        fault_q;
  logic [31:0] cnt_q;
  logic [31:0] load_result;
  logic        misalign;
  logic        req_ok;
  logic        timeout_hit;

`ifdef MISALIGN_TRAP_EN
  assign misalign = (((req_opcode == OP_LH) || (req_opcode == OP_LHU) ||
                      (req_opcode == OP_SH)) && req_addr[0]) ||
                    (((req_opcode == OP_LW) || (req_opcode == OP_SW)) &&
                      (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_ok      = (is_load(req_opcode) || is_store(req_opcode)) && !misalign;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  load_extract u_extract (
    .word   (mem_rdata),
    .addr   (addr_q[1:0]),
    .opcode (op_q),
    .result (load_result)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // a value unassigned and infer a latch.
    state_d   = state_q;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    fault     = 1'b0;
    wb_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!req_ok)                  state_d = RESP;
          else if (req_opcode == OP_SW) state_d = WR;
          else                          state_d = RD;
        end
      end
      RD: begin
        mem_req = 1'b1;
        if (mem_ack)          state_d = is_load(op_q) ? RESP : WR;
        else if (timeout_hit) state_d = RESP;
      end
      WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack || timeout_hit) state_d = RESP;
      end
      RESP: begin
        done     = 1'b1;
        fault    = fault_q;
        wb_valid = !fault_q && is_load(op_q);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign wb_rd     = rd_q;
  assign wb_data   = wb_data_q;

  // Request capture, read-data handling, fault flag and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      addr_q    <= '0;
      rd_q      <= '0;
      wdata_q   <= '0;
      wb_data_q <= '0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        op_q    <= req_opcode;
        addr_q  <= req_addr;
        rd_q    <= req_rd;
        wdata_q <= req_wdata;
        fault_q <= !req_ok;
      end
      if (state_q == RD && mem_ack) begin
        // Loads keep the extracted result; sb/sh turn the read into the write word.
        wb_data_q <= load_result;
        wdata_q   <= lane_merge(mem_rdata, wdata_q, addr_q[1:0], op_q);
      end
      if (mem_req && !mem_ack && timeout_hit)
        fault_q <= 1'b1;
      if ((state_d == RD || state_d == WR) && state_d != state_q)
        cnt_q <= '0;
      else if (mem_req)
        cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_load_store_seq.sv
// Directed testbench for load_store_seq: a driver issues requests and plays
// the memory side, pushing the expected response of each request into a
// scoreboard queue; a monitor pops and compares on every done pulse.
module tb_load_store_seq;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done;
  logic        fault;

  typedef struct packed {
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        flt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  load_store_seq #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .done       (done),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void expect_resp(input logic wb, input logic [4:0] rd,
                                      input logic [31:0] data, input logic flt);
    exp_t e;
    e.wb = wb; e.rd = rd; e.data = data; e.flt = flt;
    sb_q.push_back(e);
  endfunction

  // Monitor: compare every response pulse against the scoreboard.
  always @(negedge clk) begin
    if (done) begin
      check("done_one_cycle", {31'd0, prev_done}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_fault", {31'd0, fault}, {31'd0, e.flt});
        check("resp_wb_valid", {31'd0, wb_valid}, {31'd0, e.wb});
        if (e.wb) begin
          check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
          check("wb_data", wb_data, e.data);
        end
      end
    end else if (wb_valid || fault) begin
      check("stray_pulse", {30'd0, wb_valid, fault}, 32'd0);
    end
    prev_done = done;
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_opcode = op;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Checks the access presented in the next cycle, then acks it on the
  // delay-th cycle of mem_req.
  task automatic serve(input logic exp_we, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wdata, input logic [31:0] rdata,
                       input int delay);
    @(negedge clk);
    check("mem_req", {31'd0, mem_req}, 32'd1);
    check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
    check("mem_addr", mem_addr, exp_addr);
    if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
    for (int i = 1; i < delay; i++) @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic finish_chk();
    @(negedge clk);
    check("done_latency", {31'd0, done}, 32'd1);
    check("ready_in_resp", {31'd0, req_ready}, 32'd0);
    check("mem_req_in_resp", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b1; req_valid = 1'b0; req_opcode = '0; req_addr = '0;
    req_wdata = '0; req_rd = '0; mem_ack = 1'b0; mem_rdata = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_outputs", {26'd0, mem_req, mem_we, done, fault, wb_valid, 1'b0}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // lbu from lane 3, zero-extended
    expect_resp(1'b1, 5'd7, 32'h0000_0080, 1'b0);
    issue(OP_LBU, 32'h0000_1003, 32'h0, 5'd7);
    serve(1'b0, 32'h0000_1000, 32'h0, 32'h80FF_1234, 2);
    finish_chk();

    // lh from upper half, sign-extended
    expect_resp(1'b1, 5'd3, 32'hFFFF_8001, 1'b0);
    issue(OP_LH, 32'h0000_2002, 32'h0, 5'd3);
    serve(1'b0, 32'h0000_2000, 32'h0, 32'h8001_0000, 1);
    finish_chk();

    // lb from lane 2, sign-extended
    expect_resp(1'b1, 5'd1, 32'hFFFF_FFF5, 1'b0);
    issue(OP_LB, 32'h0000_0012, 32'h0, 5'd1);
    serve(1'b0, 32'h0000_0010, 32'h0, 32'h00F5_0000, 3);
    finish_chk();

    // lhu from lower half, zero-extended
    expect_resp(1'b1, 5'd9, 32'h0000_ABCD, 1'b0);
    issue(OP_LHU, 32'h0000_0004, 32'h0, 5'd9);
    serve(1'b0, 32'h0000_0004, 32'h0, 32'h1234_ABCD, 1);
    finish_chk();

    // lw passes the word
    expect_resp(1'b1, 5'd31, 32'hDEAD_BEEF, 1'b0);
    issue(OP_LW, 32'h0000_0008, 32'h0, 5'd31);
    serve(1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 4);
    finish_chk();

    // sb read-modify-write into lane 1
    expect_resp(1'b0, 5'd0, 32'h0, 1'b0);
    issue(OP_SB, 32'h0000_0001, 32'h0000_00AB, 5'd0);
    serve(1'b0, 32'h0000_0000, 32'h0, 32'h1122_3344, 2);
    serve(1'b1, 32'h0000_0000, 32'h1122_AB44, 32'h0, 1);
    finish_chk();

    // sh read-modify-write into upper half
    expect_resp(1'b0, 5'd0, 32'h0, 1'b0);
    issue(OP_SH, 32'h0000_0102, 32'hFFFF_5566, 5'd0);
    serve(1'b0, 32'h0000_0100, 32'h0, 32'hAAAA_BBBB, 1);
    serve(1'b1, 32'h0000_0100, 32'h5566_BBBB, 32'h0, 2);
    finish_chk();

    // sw writes directly
    expect_resp(1'b0, 5'd0, 32'h0, 1'b0);
    issue(OP_SW, 32'h0000_0200, 32'hCAFE_F00D, 5'd0);
    serve(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 1);
    finish_chk();

    // unsupported opcode faults without memory access
    expect_resp(1'b0, 5'd0, 32'h0, 1'b1);
    issue(6'b000000, 32'h0000_0040, 32'h0, 5'd4);
    finish_chk();

    // misaligned lw
`ifdef MISALIGN_TRAP_EN
    expect_resp(1'b0, 5'd0, 32'h0, 1'b1);
    issue(OP_LW, 32'h0000_0006, 32'h0, 5'd5);
    finish_chk();
`else
    expect_resp(1'b1, 5'd5, 32'h0102_0304, 1'b0);
    issue(OP_LW, 32'h0000_0006, 32'h0, 5'd5);
    serve(1'b0, 32'h0000_0004, 32'h0, 32'h0102_0304, 1);
    finish_chk();
`endif

    // ack while idle is ignored
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(posedge clk);
    #1 mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    check("idle_ack_ignored", {29'd0, mem_req, done, req_ready}, 32'd1);

    // timeout: lw never acked
    expect_resp(1'b0, 5'd0, 32'h0, 1'b1);
    issue(OP_LW, 32'h0000_0300, 32'h0, 5'd6);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mem_req) break;
      cnt++;
    end
    check("timeout_req_cycles", cnt, 32'd4);
    check("timeout_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("timeout_ready_back", {31'd0, req_ready}, 32'd1);

    // reset during WR abandons the store
    issue(OP_SW, 32'h0000_0400, 32'h0000_0055, 5'd0);
    @(negedge clk);
    check("pre_reset_wr", {30'd0, mem_req, mem_we}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_ready", {31'd0, req_ready}, 32'd1);
    check("reset_done", {30'd0, done, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", {31'd0, req_ready}, 32'd1);

    expect_resp(1'b0, 5'd0, 32'h0, 1'b0);
    issue(OP_SW, 32'h0000_0404, 32'h0000_0077, 5'd0);
    serve(1'b1, 32'h0000_0404, 32'h0000_0077, 32'h0, 2);
    finish_chk();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
